// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates the RV32I branch condition, forms the target,
// checks it against the fetch-time prediction and keeps saturating predictor statistics.
module branch_resolve_unit #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int ILEN_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_stats,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    output logic             br_taken,
    output logic             br_eq,
    output logic             br_lt,
    output logic [XLEN-1:0]  br_target,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    typedef struct packed {
        logic            valid;
        logic            taken;
        logic            eq;
        logic            lt;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] redirect;
        logic            misp;
        logic            ill;
    } brRes_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    brRes_t nxt, res;
    logic   ltSigned, ltUnsigned, countEn;
    logic [XLEN-1:0] fallThru;

    always_comb begin
        nxt        = '0;
        ltSigned   = $signed(rs1_data) < $signed(rs2_data);
        ltUnsigned = rs1_data < rs2_data;
        fallThru   = pc + XLEN'(ILEN_BYTES);
        nxt.valid  = in_valid;
        nxt.eq     = (rs1_data == rs2_data);
        // funct3[1] selects unsigned compare for both BLTU/BGEU and the reserved codes
        nxt.lt     = !nxt.eq && (funct3[1] ? ltUnsigned : ltSigned);
        nxt.target = pc + imm;
        case (funct3)
            3'b000:  nxt.taken = nxt.eq;
            3'b001:  nxt.taken = !nxt.eq;
            3'b100:  nxt.taken = ltSigned;
            3'b101:  nxt.taken = !ltSigned;
            3'b110:  nxt.taken = ltUnsigned;
            3'b111:  nxt.taken = !ltUnsigned;
            default: nxt.ill   = 1'b1;
        endcase
        nxt.redirect = nxt.taken ? nxt.target : fallThru;
        nxt.misp     = in_valid && !nxt.ill &&
                       ((nxt.taken != pred_taken) ||
                        (nxt.taken && (pred_target != nxt.target)));
        nxt.ill      = nxt.ill && in_valid;
        countEn      = in_valid && !stall && !flush && !nxt.ill;
    end

    // Flush only kills the control bits; the datapath fields may stay stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if (flush) begin
            res.valid <= 1'b0;
            res.misp  <= 1'b0;
            res.ill   <= 1'b0;
        end else if (!stall) begin
            res <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (clr_stats) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (countEn) begin
            if (br_count != CNT_MAX)
                br_count <= br_count + 1'b1;
            if (nxt.misp && mispred_count != CNT_MAX)
                mispred_count <= mispred_count + 1'b1;
        end
    end

    assign out_valid   = res.valid;
    assign br_taken    = res.taken;
    assign br_eq       = res.eq;
    assign br_lt       = res.lt;
    assign br_target   = res.target;
    assign redirect_pc = res.redirect;
    assign mispredict  = res.misp;
    assign illegal     = res.ill;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit; a scoreboard queue holds the expected
// per-cycle response and a negedge monitor compares it against the registered outputs.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, stall, flush, clr_stats, pred_taken;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1_data, rs2_data, pc, imm, pred_target;
    logic             out_valid, br_taken, br_eq, br_lt, mispredict, illegal;
    logic [XLEN-1:0]  br_target, redirect_pc;
    logic [CNT_W-1:0] br_count, mispred_count;

    typedef struct {
        logic            v, tk, eq, lt, mp, il;
        logic [XLEN-1:0] tgt, rpc;
        logic [CNT_W-1:0] bc, mc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   sbIdx = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .ILEN_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .clr_stats(clr_stats), .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .br_taken(br_taken), .br_eq(br_eq), .br_lt(br_lt),
        .br_target(br_target), .redirect_pc(redirect_pc), .mispredict(mispredict),
        .illegal(illegal), .br_count(br_count), .mispred_count(mispred_count)
    );

    function automatic exp_t mk(logic v, logic tk, logic eq, logic lt, logic [XLEN-1:0] tgt,
                                logic [XLEN-1:0] rpc, logic mp, logic il,
                                logic [CNT_W-1:0] bc, logic [CNT_W-1:0] mc);
        exp_t e;
        e.v = v; e.tk = tk; e.eq = eq; e.lt = lt; e.tgt = tgt; e.rpc = rpc;
        e.mp = mp; e.il = il; e.bc = bc; e.mc = mc;
        return e;
    endfunction

    // One stimulus cycle: drive just after the negedge, result checked at the next negedge.
    task automatic drive(input logic iv, input logic st, input logic fl, input logic cl,
                         input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                         input logic pt, input logic [XLEN-1:0] ptg, input exp_t e);
        @(negedge clk);
        #1;
        in_valid = iv; stall = st; flush = fl; clr_stats = cl; funct3 = f3;
        rs1_data = a; rs2_data = b; pc = p; imm = im; pred_taken = pt; pred_target = ptg;
        q.push_back(e);
    endtask

    task automatic idleInputs();
        in_valid = 0; stall = 0; flush = 0; clr_stats = 0; funct3 = 3'b000;
        rs1_data = '0; rs2_data = '0; pc = '0; imm = '0; pred_taken = 0; pred_target = '0;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic err;
            e   = q.pop_front();
            err = (out_valid !== e.v) || (mispredict !== e.mp) || (illegal !== e.il) ||
                  (br_count !== e.bc) || (mispred_count !== e.mc);
            if (e.v)
                err = err || (br_taken !== e.tk) || (br_eq !== e.eq) || (br_lt !== e.lt) ||
                      (br_target !== e.tgt) || (redirect_pc !== e.rpc);
            total++;
            if (err) begin
                bad++;
                $display("FAIL sb#%0d got v=%b tk=%b eq=%b lt=%b tgt=%h rpc=%h mp=%b il=%b bc=%0d mc=%0d expected v=%b tk=%b eq=%b lt=%b tgt=%h rpc=%h mp=%b il=%b bc=%0d mc=%0d",
                         sbIdx, out_valid, br_taken, br_eq, br_lt, br_target, redirect_pc,
                         mispredict, illegal, br_count, mispred_count,
                         e.v, e.tk, e.eq, e.lt, e.tgt, e.rpc, e.mp, e.il, e.bc, e.mc);
            end
            sbIdx++;
        end
    end

    initial begin
        rst_n = 1'b0;
        idleInputs();
        #3;
        total++;
        if ({out_valid, br_taken, br_eq, br_lt, br_target, redirect_pc, mispredict, illegal,
             br_count, mispred_count} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%b mp=%b il=%b tgt=%h rpc=%h bc=%0d mc=%0d expected all zero",
                     out_valid, mispredict, illegal, br_target, redirect_pc, br_count, mispred_count);
        end
        #9 rst_n = 1'b1;

        // BLT signed -1 < 1, correctly predicted
        drive(1,0,0,0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1, 32'h120,
              mk(1,1,0,1, 32'h120, 32'h120, 0,0, 2'd1, 2'd0));
        // BLTU same operands: not taken, predicted taken
        drive(1,0,0,0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1, 32'h120,
              mk(1,0,0,0, 32'h120, 32'h104, 1,0, 2'd2, 2'd1));
        // BEQ taken, wrong BTB target
        drive(1,0,0,0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h40, 1, 32'h200,
              mk(1,1,1,0, 32'h140, 32'h140, 1,0, 2'd3, 2'd2));
        // BNE taken, target wraps; clr_stats wins over the increment
        drive(1,0,0,1, 3'b001, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'h20, 1, 32'h10,
              mk(1,1,0,1, 32'h10, 32'h10, 0,0, 2'd0, 2'd0));
        // BNE not taken, fall-through near the top of the address space
        drive(1,0,0,0, 3'b001, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'h20, 0, 32'h0,
              mk(1,0,1,0, 32'h10, 32'hFFFF_FFF4, 0,0, 2'd1, 2'd0));
        // BGE: 3 >= INT_MIN signed, negative immediate
        drive(1,0,0,0, 3'b101, 32'h3, 32'h8000_0000, 32'h200, 32'hFFFF_FFF8, 0, 32'h0,
              mk(1,1,0,0, 32'h1F8, 32'h1F8, 1,0, 2'd2, 2'd1));
        // BGEU: 3 < 0x8000_0000 unsigned, not taken
        drive(1,0,0,0, 3'b111, 32'h3, 32'h8000_0000, 32'h300, 32'h10, 0, 32'h0,
              mk(1,0,0,1, 32'h310, 32'h304, 0,0, 2'd3, 2'd1));
        // br_count saturates at 3
        drive(1,0,0,0, 3'b100, 32'h1, 32'h2, 32'h400, 32'h8, 0, 32'h0,
              mk(1,1,0,1, 32'h408, 32'h408, 1,0, 2'd3, 2'd2));
        // reserved funct3: illegal, no mispredict, not counted
        drive(1,0,0,0, 3'b010, 32'h1, 32'h2, 32'h500, 32'h40, 1, 32'h0,
              mk(1,0,0,1, 32'h540, 32'h504, 0,1, 2'd3, 2'd2));
        // mispred_count reaches 3
        drive(1,0,0,0, 3'b110, 32'h2, 32'h1, 32'h600, 32'h10, 1, 32'h610,
              mk(1,0,0,0, 32'h610, 32'h604, 1,0, 2'd3, 2'd3));
        // mispredicting result, counters cleared in the same cycle
        drive(1,0,0,1, 3'b000, 32'h9, 32'h9, 32'h700, 32'h20, 1, 32'h999,
              mk(1,1,1,0, 32'h720, 32'h720, 1,0, 2'd0, 2'd0));
        // three stalled cycles: everything frozen, nothing counted
        for (int i = 0; i < 3; i++)
            drive(1,1,0,0, 3'b001, 32'h1, 32'h2, 32'h0, 32'h0, 0, 32'h0,
                  mk(1,1,1,0, 32'h720, 32'h720, 1,0, 2'd0, 2'd0));
        // release with no branch present
        drive(0,0,0,0, 3'b001, 32'h1, 32'h2, 32'h0, 32'h0, 0, 32'h0,
              mk(0,0,0,0, 32'h0, 32'h0, 0,0, 2'd0, 2'd0));
        // flush beats stall and in_valid, illegal bit also killed
        drive(1,1,1,0, 3'b010, 32'h1, 32'h2, 32'h0, 32'h0, 1, 32'h0,
              mk(0,0,0,0, 32'h0, 32'h0, 0,0, 2'd0, 2'd0));
        drive(0,0,0,0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0,
              mk(0,0,0,0, 32'h0, 32'h0, 0,0, 2'd0, 2'd0));
        drive(1,0,0,0, 3'b000, 32'h1, 32'h1, 32'h800, 32'h100, 1, 32'h901,
              mk(1,1,1,0, 32'h900, 32'h900, 1,0, 2'd1, 2'd1));

        // asynchronous reset mid-operation
        @(negedge clk);
        #1 idleInputs();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || mispredict !== 1'b0 || br_count !== '0 || mispred_count !== '0) begin
            bad++;
            $display("FAIL mid_reset got v=%b mp=%b bc=%0d mc=%0d expected 0 0 0 0",
                     out_valid, mispredict, br_count, mispred_count);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1,0,0,0, 3'b001, 32'h1, 32'h2, 32'h0, 32'h8, 1, 32'h8,
              mk(1,1,0,1, 32'h8, 32'h8, 0,0, 2'd1, 2'd0));

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            idleInputs();
            if (q.size() == 0) break;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
